// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default datapath widths, register/word types, r0 index.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

  // Architectural zero register index.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the GPR file.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   rd_addr    packed read indices looked up for busy status
//   wr_hit     one bit per register: written this cycle (r0 already filtered out)
//   iss_en     mark iss_addr pending
//   iss_addr   issued destination index
//   rd_busy    pending bit per read port, masked by same-cycle write when BYPASS=1
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NUM_RD  = 3,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [(1<<ADDR_W)-1:0]   wr_hit,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] iss_set;

  // Issue decode; r0 never becomes pending when hardwired.
  always_comb begin
    iss_set = '0;
    if (iss_en && !(ZERO_R0 && (iss_addr == ADDR_W'(REG_ZERO))))
      iss_set[iss_addr] = 1'b1;
  end

  // Clear on write, then set on issue so the newer producer wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~wr_hit) | iss_set;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] ra;
    assign ra         = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = pending[ra] & ~(BYPASS & wr_hit[ra]);
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file with same-cycle write->read bypass and pending-write scoreboard.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   rd_addr      packed read indices (NUM_RD x ADDR_W)
//   rd_data      packed combinational read data (NUM_RD x DATA_W)
//   rd_busy      scoreboard pending bit per read port
//   wr_en        write enables (NUM_WR), higher port index has priority
//   wr_addr      packed write indices
//   wr_data      packed write data
//   iss_en       mark iss_addr pending
//   iss_addr     issued destination index
//   wr_conflict  sticky flag: two enabled writes hit one register in one cycle
module regfile_mp_sb
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NUM_RD  = 3,
  parameter int unsigned NUM_WR  = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     wr_conflict
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] wa   [NUM_WR];
  logic [DATA_W-1:0] wd   [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [DEPTH-1:0]  wr_hit;
  logic              conflict_c;

  // Effective write per port: enabled, not in reset, not a dropped r0 write.
  for (genvar p = 0; p < NUM_WR; p++) begin : g_wport
    assign wa[p]    = wr_addr[p*ADDR_W +: ADDR_W];
    assign wd[p]    = wr_data[p*DATA_W +: DATA_W];
    assign wr_ok[p] = wr_en[p] & ~rst & ~(ZERO_R0 & (wa[p] == ADDR_W'(REG_ZERO)));
  end

  // Registers touched this cycle, for scoreboard clear and busy masking.
  always_comb begin
    wr_hit = '0;
    for (int p = 0; p < NUM_WR; p++)
      if (wr_ok[p]) wr_hit[wa[p]] = 1'b1;
  end

  // Any pair of effective writes to the same index.
  always_comb begin
    conflict_c = 1'b0;
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (wr_ok[p] && wr_ok[q] && (wa[p] == wa[q])) conflict_c = 1'b1;
  end

  // Storage; later ports overwrite earlier ones, giving higher index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (wr_ok[p]) regs[wa[p]] <= wd[p];
    end
  end

  // Read ports with optional bypass using the same port priority as the write.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rport
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      d = regs[ra];
      if (BYPASS)
        for (int p = 0; p < NUM_WR; p++)
          if (wr_ok[p] && (wa[p] == ra)) d = wd[p];
    end
    assign rd_data[i*DATA_W +: DATA_W] = d;
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             wr_conflict <= 1'b0;
    else if (conflict_c) wr_conflict <= 1'b1;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .BYPASS  (BYPASS),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .wr_hit   (wr_hit),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .rd_busy  (rd_busy)
  );

endmodule
